// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Time-based green-phase scheduler for a four-road intersection (roads A-D).
// The road with the highest sensor density wins green; ties rotate through a
// round-robin pointer. Emergency requests preempt the normal cycle. Every green
// runs through yellow and all-red clearance before the next green is given.
//
// Ports:
//   clock          rising-edge clock
//   clear          synchronous active-high reset, overrides every other input
//   tick           timebase enable; phase timers advance only when high
//   dens_a..dens_d 3-bit sensor groups {x3,x2,x1}; density level = popcount
//   emerg          emergency requests, bit0 = A .. bit3 = D
//   lights         registered light vector; per road red=100 yellow=010
//                  green=001; A [11:9], B [8:6], C [5:3], D [2:0]
//   grant          one-hot road owning the phase (0 in IDLE/ARB/ALLRED)
//   phase          0 IDLE, 1 ARB, 2 GREEN, 3 YELLOW, 4 ALLRED, 5 PREEMPT
//   emerg_active   high while in PREEMPT
module traffic_phase_scheduler #(
    parameter int CNT_W      = 5,
    parameter int MIN_GREEN  = 4,
    parameter int GREEN_UNIT = 4,
    parameter int MAX_GREEN  = 12,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        tick,
    input  logic [2:0]  dens_a,
    input  logic [2:0]  dens_b,
    input  logic [2:0]  dens_c,
    input  logic [2:0]  dens_d,
    input  logic [3:0]  emerg,
    output logic [11:0] lights,
    output logic [3:0]  grant,
    output logic [2:0]  phase,
    output logic        emerg_active
);

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_ARB     = 3'd1;
    localparam logic [2:0] PH_GREEN   = 3'd2;
    localparam logic [2:0] PH_YELLOW  = 3'd3;
    localparam logic [2:0] PH_ALLRED  = 3'd4;
    localparam logic [2:0] PH_PREEMPT = 3'd5;

    localparam logic [11:0]      ALL_RED = 12'b100100100100;
    localparam logic [CNT_W-1:0] C_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_MING  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] C_YEL   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] C_ALR   = CNT_W'(ALLRED_T);

    function automatic logic [1:0] popcount3(input logic [2:0] d);
        return {1'b0, d[0]} + {1'b0, d[1]} + {1'b0, d[2]};
    endfunction

    // Lowest-index set bit; callers only use it when at least one bit is set.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] road);
        return 4'b0001 << road;
    endfunction

    function automatic logic [CNT_W-1:0] green_time(input logic [1:0] lvl);
        int g;
        g = MIN_GREEN + GREEN_UNIT * (int'(lvl) - 1);
        if (g > MAX_GREEN) g = MAX_GREEN;
        else               g = g;
        return CNT_W'(g);
    endfunction

    // Light vector with one road showing the given lamp and the rest red.
    function automatic logic [11:0] road_lamp(input logic [1:0] road, input logic [2:0] lamp);
        case (road)
            2'd0:    return {lamp, 9'b100100100};
            2'd1:    return {3'b100, lamp, 6'b100100};
            2'd2:    return {6'b100100, lamp, 3'b100};
            default: return {9'b100100100, lamp};
        endcase
    endfunction

    logic [2:0]       r_phase;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_elapsed;
    logic [1:0]       r_road;
    logic [1:0]       r_ptr;
    logic [11:0]      r_lights;
    logic [3:0]       r_grant;
    logic             r_emerg_active;

    logic [2:0]       w_phase_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] w_elapsed_nxt;
    logic [1:0]       w_road_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [11:0]      w_lights_nxt;
    logic [3:0]       w_grant_nxt;
    logic             w_emerg_nxt;

    logic [1:0]       w_lvl [4];
    logic [1:0]       w_max_lvl;
    logic [1:0]       w_winner;
    logic [1:0]       w_idx;
    logic             w_found;
    logic             w_any_dens;
    logic             w_any_emerg;
    logic [1:0]       w_emerg_road;
    logic             w_own_emerg;
    logic             w_other_emerg;
    logic             w_timer_exp;

    assign w_lvl[0]      = popcount3(dens_a);
    assign w_lvl[1]      = popcount3(dens_b);
    assign w_lvl[2]      = popcount3(dens_c);
    assign w_lvl[3]      = popcount3(dens_d);
    assign w_any_dens    = (w_max_lvl != 2'd0);
    assign w_any_emerg   = |emerg;
    assign w_emerg_road  = lowest_set(emerg);
    assign w_own_emerg   = emerg[r_road];
    assign w_other_emerg = |(emerg & ~onehot4(r_road));
    // Treat a zero timer as expired so a corrupted count cannot stall a phase.
    assign w_timer_exp   = (r_timer <= C_ONE);

    assign lights       = r_lights;
    assign grant        = r_grant;
    assign phase        = r_phase;
    assign emerg_active = r_emerg_active;

    // Arbitration: highest density level, ties broken searching from the pointer.
    always_comb begin
        w_max_lvl = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_lvl[i] > w_max_lvl) w_max_lvl = w_lvl[i];
            else                      w_max_lvl = w_max_lvl;
        end
        w_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && (w_lvl[w_idx] == w_max_lvl)) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // State register, including the registered outputs of the state being entered.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_phase        <= PH_IDLE;
            r_timer        <= C_ZERO;
            r_elapsed      <= C_ZERO;
            r_road         <= 2'd0;
            r_ptr          <= 2'd0;
            r_lights       <= ALL_RED;
            r_grant        <= 4'b0000;
            r_emerg_active <= 1'b0;
        end else begin
            r_phase        <= w_phase_nxt;
            r_timer        <= w_timer_nxt;
            r_elapsed      <= w_elapsed_nxt;
            r_road         <= w_road_nxt;
            r_ptr          <= w_ptr_nxt;
            r_lights       <= w_lights_nxt;
            r_grant        <= w_grant_nxt;
            r_emerg_active <= w_emerg_nxt;
        end
    end

    // Next-state and timer logic.
    always_comb begin
        w_phase_nxt   = r_phase;
        w_timer_nxt   = r_timer;
        w_elapsed_nxt = r_elapsed;
        w_road_nxt    = r_road;
        w_ptr_nxt     = r_ptr;
        case (r_phase)
            PH_IDLE: begin
                w_timer_nxt = C_ZERO;
                if (w_any_emerg) begin
                    w_phase_nxt = PH_PREEMPT;
                    w_road_nxt  = w_emerg_road;
                end else if (w_any_dens) begin
                    w_phase_nxt = PH_ARB;
                end else begin
                    w_phase_nxt = PH_IDLE;
                end
            end
            PH_ARB: begin
                if (w_any_dens) begin
                    w_phase_nxt   = PH_GREEN;
                    w_road_nxt    = w_winner;
                    w_ptr_nxt     = w_winner + 2'd1;
                    w_timer_nxt   = green_time(w_max_lvl);
                    w_elapsed_nxt = C_ZERO;
                end else begin
                    w_phase_nxt   = PH_IDLE;
                    w_timer_nxt   = C_ZERO;
                end
            end
            PH_GREEN: begin
                // Own emergency first (straight to PREEMPT, lamp stays green),
                // then foreign emergency or an empty approach past minimum green.
                if (w_own_emerg) begin
                    w_phase_nxt = PH_PREEMPT;
                end else if (w_other_emerg ||
                             ((w_lvl[r_road] == 2'd0) && (r_elapsed >= C_MING))) begin
                    w_phase_nxt = PH_YELLOW;
                    w_timer_nxt = C_YEL;
                end else if (tick) begin
                    if (r_elapsed != C_SAT) w_elapsed_nxt = r_elapsed + C_ONE;
                    else                    w_elapsed_nxt = r_elapsed;
                    if (w_timer_exp) begin
                        w_phase_nxt = PH_YELLOW;
                        w_timer_nxt = C_YEL;
                    end else begin
                        w_timer_nxt = r_timer - C_ONE;
                    end
                end else begin
                    w_phase_nxt = PH_GREEN;
                end
            end
            PH_YELLOW: begin
                if (tick && w_timer_exp) begin
                    w_phase_nxt = PH_ALLRED;
                    w_timer_nxt = C_ALR;
                end else if (tick) begin
                    w_timer_nxt = r_timer - C_ONE;
                end else begin
                    w_phase_nxt = PH_YELLOW;
                end
            end
            PH_ALLRED: begin
                if (tick && w_timer_exp) begin
                    w_timer_nxt = C_ZERO;
                    if (w_any_emerg) begin
                        w_phase_nxt = PH_PREEMPT;
                        w_road_nxt  = w_emerg_road;
                    end else if (w_any_dens) begin
                        w_phase_nxt = PH_ARB;
                    end else begin
                        w_phase_nxt = PH_IDLE;
                    end
                end else if (tick) begin
                    w_timer_nxt = r_timer - C_ONE;
                end else begin
                    w_phase_nxt = PH_ALLRED;
                end
            end
            PH_PREEMPT: begin
                // Only the preempting road's own request matters here.
                if (!w_own_emerg) begin
                    w_phase_nxt = PH_YELLOW;
                    w_timer_nxt = C_YEL;
                end else begin
                    w_phase_nxt = PH_PREEMPT;
                end
            end
            default: begin
                w_phase_nxt = PH_IDLE;
                w_timer_nxt = C_ZERO;
            end
        endcase
    end

    // Output decode of the state being entered, registered with the state.
    always_comb begin
        w_lights_nxt = ALL_RED;
        w_grant_nxt  = 4'b0000;
        w_emerg_nxt  = 1'b0;
        case (w_phase_nxt)
            PH_GREEN: begin
                w_lights_nxt = road_lamp(w_road_nxt, 3'b001);
                w_grant_nxt  = onehot4(w_road_nxt);
            end
            PH_PREEMPT: begin
                w_lights_nxt = road_lamp(w_road_nxt, 3'b001);
                w_grant_nxt  = onehot4(w_road_nxt);
                w_emerg_nxt  = 1'b1;
            end
            PH_YELLOW: begin
                w_lights_nxt = road_lamp(w_road_nxt, 3'b010);
                w_grant_nxt  = onehot4(w_road_nxt);
            end
            default: begin
                w_lights_nxt = ALL_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: a per-cycle vector table for
// the basic cycle and foreign-emergency preemption, plus hand-written
// sequences for round-robin ties, early termination, own-road preemption,
// tick freezing and reset during preemption.
module tb_traffic_phase_scheduler;

    localparam logic [11:0] L_RED = 12'b100100100100;
    localparam logic [11:0] L_GA  = 12'b001100100100;
    localparam logic [11:0] L_YA  = 12'b010100100100;
    localparam logic [11:0] L_GB  = 12'b100001100100;
    localparam logic [11:0] L_YB  = 12'b100010100100;
    localparam logic [11:0] L_GC  = 12'b100100001100;
    localparam logic [11:0] L_YC  = 12'b100100010100;
    localparam logic [11:0] L_GD  = 12'b100100100001;
    localparam logic [11:0] L_YD  = 12'b100100100010;

    localparam logic [2:0] P_IDLE = 3'd0, P_ARB = 3'd1, P_GRN = 3'd2,
                           P_YEL = 3'd3, P_ALR = 3'd4, P_PRE = 3'd5;

    logic        clock = 1'b0;
    logic        clear, tick;
    logic [2:0]  dens_a, dens_b, dens_c, dens_d;
    logic [3:0]  emerg;
    logic [11:0] lights;
    logic [3:0]  grant;
    logic [2:0]  phase;
    logic        emerg_active;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        clr;
        logic        tk;
        logic [2:0]  da, db, dc, dd;
        logic [3:0]  em;
        logic [2:0]  ph;
        logic [11:0] lt;
        logic [3:0]  gr;
        logic        ea;
    } vec_t;

    vec_t vecs [30];

    traffic_phase_scheduler dut (
        .clock        (clock),
        .clear        (clear),
        .tick         (tick),
        .dens_a       (dens_a),
        .dens_b       (dens_b),
        .dens_c       (dens_c),
        .dens_d       (dens_d),
        .emerg        (emerg),
        .lights       (lights),
        .grant        (grant),
        .phase        (phase),
        .emerg_active (emerg_active)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic clr, input logic tk,
                                input logic [2:0] da, input logic [2:0] db,
                                input logic [2:0] dc, input logic [2:0] dd,
                                input logic [3:0] em, input logic [2:0] ph,
                                input logic [11:0] lt, input logic [3:0] gr,
                                input logic ea);
        vec_t v;
        v.clr = clr; v.tk = tk; v.da = da; v.db = db; v.dc = dc; v.dd = dd;
        v.em = em; v.ph = ph; v.lt = lt; v.gr = gr; v.ea = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] ph,
                         input logic [11:0] lt, input logic [3:0] gr, input logic ea);
        checks++;
        if ({phase, lights, grant, emerg_active} !== {ph, lt, gr, ea}) begin
            errors++;
            $display("FAIL %s: got phase=%0d lights=%b grant=%b emerg_active=%b, want phase=%0d lights=%b grant=%b emerg_active=%b",
                     name, phase, lights, grant, emerg_active, ph, lt, gr, ea);
        end
    endtask

    // Run n clock edges with the current inputs, checking after each edge.
    task automatic expect_n(input int n, input string name, input logic [2:0] ph,
                            input logic [11:0] lt, input logic [3:0] gr, input logic ea);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s[%0d]", name, k), ph, lt, gr, ea);
        end
    endtask

    task automatic do_reset();
        clear = 1'b1; tick = 1'b1; emerg = 4'b0000;
        dens_a = 3'b000; dens_b = 3'b000; dens_c = 3'b000; dens_d = 3'b000;
        expect_n(1, "reset", P_IDLE, L_RED, 4'b0000, 1'b0);
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1; tick = 1'b1; emerg = 4'b0000;
        dens_a = 3'b000; dens_b = 3'b000; dens_c = 3'b000; dens_d = 3'b000;

        // Basic B cycle (level 2 -> 8 green), then foreign emergency on A green.
        vecs[0]  = mk(1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0, P_IDLE, L_RED, 4'b0000, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0, P_IDLE, L_RED, 4'b0000, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 4'h0, P_ARB,  L_RED, 4'b0000, 1'b0);
        for (int i = 3; i <= 10; i++)
            vecs[i] = mk(1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 4'h0, P_GRN, L_GB, 4'b0010, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 4'h0, P_YEL,  L_YB,  4'b0010, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 4'h0, P_YEL,  L_YB,  4'b0010, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 4'h0, P_ALR,  L_RED, 4'b0000, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 4'h0, P_ARB,  L_RED, 4'b0000, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 4'h0, P_GRN,  L_GB,  4'b0010, 1'b0);
        vecs[16] = mk(1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0, P_IDLE, L_RED, 4'b0000, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h0, P_ARB,  L_RED, 4'b0000, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h0, P_GRN,  L_GA,  4'b0001, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h0, P_GRN,  L_GA,  4'b0001, 1'b0);
        vecs[20] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h0, P_GRN,  L_GA,  4'b0001, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h8, P_YEL,  L_YA,  4'b0001, 1'b0);
        vecs[22] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h8, P_YEL,  L_YA,  4'b0001, 1'b0);
        vecs[23] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h8, P_ALR,  L_RED, 4'b0000, 1'b0);
        vecs[24] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h8, P_PRE,  L_GD,  4'b1000, 1'b1);
        vecs[25] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h8, P_PRE,  L_GD,  4'b1000, 1'b1);
        vecs[26] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h0, P_YEL,  L_YD,  4'b1000, 1'b0);
        vecs[27] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h0, P_YEL,  L_YD,  4'b1000, 1'b0);
        vecs[28] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h0, P_ALR,  L_RED, 4'b0000, 1'b0);
        vecs[29] = mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 4'h0, P_ARB,  L_RED, 4'b0000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            clear = vecs[i].clr; tick = vecs[i].tk; emerg = vecs[i].em;
            dens_a = vecs[i].da; dens_b = vecs[i].db; dens_c = vecs[i].dc; dens_d = vecs[i].dd;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].lt, vecs[i].gr, vecs[i].ea);
        end

        // Tie A/C at level 1: A, then C via the pointer, then A again.
        do_reset();
        dens_a = 3'b001; dens_c = 3'b001;
        expect_n(1, "tie_arb1", P_ARB, L_RED, 4'b0000, 1'b0);
        expect_n(4, "tie_gA",   P_GRN, L_GA,  4'b0001, 1'b0);
        expect_n(2, "tie_yA",   P_YEL, L_YA,  4'b0001, 1'b0);
        expect_n(1, "tie_ar1",  P_ALR, L_RED, 4'b0000, 1'b0);
        expect_n(1, "tie_arb2", P_ARB, L_RED, 4'b0000, 1'b0);
        expect_n(4, "tie_gC",   P_GRN, L_GC,  4'b0100, 1'b0);
        expect_n(2, "tie_yC",   P_YEL, L_YC,  4'b0100, 1'b0);
        expect_n(1, "tie_ar2",  P_ALR, L_RED, 4'b0000, 1'b0);
        expect_n(1, "tie_arb3", P_ARB, L_RED, 4'b0000, 1'b0);
        expect_n(1, "tie_gA2",  P_GRN, L_GA,  4'b0001, 1'b0);

        // Early end: density drops after 2 ticks -> hold until elapsed reaches 4.
        do_reset();
        dens_a = 3'b111;
        expect_n(1, "early1_arb", P_ARB,  L_RED, 4'b0000, 1'b0);
        expect_n(3, "early1_g",   P_GRN,  L_GA,  4'b0001, 1'b0);
        dens_a = 3'b000;
        expect_n(2, "early1_hold", P_GRN, L_GA,  4'b0001, 1'b0);
        expect_n(2, "early1_y",   P_YEL,  L_YA,  4'b0001, 1'b0);
        expect_n(1, "early1_ar",  P_ALR,  L_RED, 4'b0000, 1'b0);
        expect_n(1, "early1_idle", P_IDLE, L_RED, 4'b0000, 1'b0);

        // Early end: density drops after 6 ticks -> yellow at the next edge.
        do_reset();
        dens_a = 3'b111;
        expect_n(1, "early2_arb", P_ARB, L_RED, 4'b0000, 1'b0);
        expect_n(7, "early2_g",   P_GRN, L_GA,  4'b0001, 1'b0);
        dens_a = 3'b000;
        expect_n(2, "early2_y",   P_YEL, L_YA,  4'b0001, 1'b0);

        // Own-road emergency: straight to PREEMPT, other requests ignored.
        do_reset();
        dens_a = 3'b111;
        expect_n(1, "pre_arb", P_ARB, L_RED, 4'b0000, 1'b0);
        expect_n(2, "pre_g",   P_GRN, L_GA,  4'b0001, 1'b0);
        emerg = 4'b0001;
        expect_n(1, "pre_a",   P_PRE, L_GA,  4'b0001, 1'b1);
        emerg = 4'b0101;
        expect_n(3, "pre_hold", P_PRE, L_GA, 4'b0001, 1'b1);
        emerg = 4'b0100;
        expect_n(2, "pre_yA",  P_YEL, L_YA,  4'b0001, 1'b0);
        expect_n(1, "pre_ar",  P_ALR, L_RED, 4'b0000, 1'b0);
        expect_n(1, "pre_c",   P_PRE, L_GC,  4'b0100, 1'b1);
        emerg = 4'b0000;
        expect_n(2, "pre_yC",  P_YEL, L_YC,  4'b0100, 1'b0);
        expect_n(1, "pre_ar2", P_ALR, L_RED, 4'b0000, 1'b0);
        expect_n(1, "pre_arb2", P_ARB, L_RED, 4'b0000, 1'b0);

        // tick=0: IDLE exit and ARB still proceed; green timer frozen.
        do_reset();
        tick = 1'b0; dens_b = 3'b011;
        expect_n(1,  "frz_arb",  P_ARB, L_RED, 4'b0000, 1'b0);
        expect_n(1,  "frz_g0",   P_GRN, L_GB,  4'b0010, 1'b0);
        expect_n(10, "frz_hold", P_GRN, L_GB,  4'b0010, 1'b0);
        tick = 1'b1;
        expect_n(7,  "frz_run",  P_GRN, L_GB,  4'b0010, 1'b0);
        expect_n(1,  "frz_y",    P_YEL, L_YB,  4'b0010, 1'b0);

        // clear during PREEMPT wins over a held request.
        do_reset();
        emerg = 4'b0010;
        expect_n(2, "clr_pre", P_PRE, L_GB, 4'b0010, 1'b1);
        clear = 1'b1;
        expect_n(1, "clr_idle", P_IDLE, L_RED, 4'b0000, 1'b0);
        clear = 1'b0; emerg = 4'b0000;
        expect_n(1, "clr_stay", P_IDLE, L_RED, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
